mini_riscv_decoder: RTL and testbench
=====================================

// Module: mini_riscv_decoder
// PURPOSE
//   Decoder counterpart to the R/I/B instruction encoders for the mini RISC-V subset:
//   takes 32-bit instruction words and emits opcode class, register fields, sign-extended
//   immediate and write-enable. Sits between instruction fetch and execute.
//   Has a valid/ready pipeline register with a one-entry skid buffer, and per-class
//   saturating retire counters.
// PARAMETERS
//   CNT_W   16   width of each retire counter (saturating)
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   in_valid     in   1   instruction word offered
//   in_ready     out  1   decoder can accept (registered)
//   in_instr     in   32  instruction word
//   in_pc        in   32  byte address of instruction, passed through
//   out_valid    out  1   decoded result valid
//   out_ready    in   1   consumer accepts result
//   out_pc       out  32  pc of decoded instruction
//   out_op       out  3   0 ADD,1 SUB,2 OR,3 AND,4 ADDI,5 BEQ,7 ILLEGAL (6 unused)
//   out_rd       out  5   destination reg (0 for BEQ/ILLEGAL)
//   out_rs1      out  5   source 1 (0 for ILLEGAL)
//   out_rs2      out  5   source 2 (0 for ADDI/ILLEGAL)
//   out_imm      out  32  sign-extended immediate (0 for R-type/ILLEGAL)
//   out_wr_en    out  1   1 for R-type/ADDI with rd!=0, else 0
//   cnt_r        out  CNT_W  R-type instructions retired at output
//   cnt_i        out  CNT_W  ADDI retired
//   cnt_b        out  CNT_W  BEQ retired
//   cnt_ill      out  CNT_W  ILLEGAL retired
// BEHAVIOUR
//   Reset (reset=0, async): out_valid=0, skid empty, in_ready=0 while asserted, =1 first
//     cycle after release; all out_* data=0; all counters=0. Reset mid-transfer drops all held words.
//   Decode (combinational on in_instr, registered at accept):
//     op 0x33: f3=000,f7=0x00 ADD; f3=000,f7=0x20 SUB; f3=110,f7=0x00 OR; f3=111,f7=0x00 AND;
//       any other f3/f7 -> ILLEGAL. 0x13 f3=000 -> ADDI; 0x63 f3=000 -> BEQ; all else ILLEGAL.
//     I imm = {{20{i[31]}}, i[31:20]}; B imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}.
//   Handshake: input accepted when in_valid&&in_ready; output consumed when out_valid&&out_ready.
//     Latency: accepted word appears on out_* the next cycle when output register is free or
//     consumed that cycle. Throughput 1/cycle with out_ready held high.
//   Skid: if word accepted while out_valid&&!out_ready, it goes into skid; in_ready=0 next cycle.
//     On output consume with skid full: skid -> output reg, in_ready=1 next cycle. Order is
//     preserved; no word is dropped or duplicated. out_* stable while out_valid&&!out_ready.
//   States: EMPTY (out_valid=0), ONE (output held), FULL (output+skid). EMPTY->ONE on accept;
//     ONE->ONE on accept+consume; ONE->EMPTY on consume only; ONE->FULL on accept w/o consume;
//     FULL->ONE on consume. In FULL, in_ready=0 and no accept is possible.
//   Counters: increment the counter for out_op's class on each output consume; they hold at
//     all-ones (saturate, no wrap). Cleared only by reset.
// TESTING
//   ADDI x1,x0,5 (0x00500093) -> op=4, rd=1, rs1=0, imm=5, wr_en=1, one cycle after accept.
//   ADDI x2,x0,-1 (imm 12'hFFF) -> imm=0xFFFFFFFF; ADDI x0,x0,0 -> wr_en=0.
//   BEQ x0,x0,+8 -> op=5, imm=8, rd=0, wr_en=0; BEQ offset 13'h1FFC -> imm=0xFFFFFFFC.
//   SUB x4,x2,x1 -> op=1, rs1=2, rs2=1; f7=0x01 f3=000 op 0x33 -> op=7, all fields 0, cnt_ill+1.
//   Stream 6 words, out_ready low for 3 cycles mid-stream -> in_ready falls one cycle after skid
//     fills; all 6 pc values out in order, none lost.
//   CNT_W=2, 5 ADDs retired -> cnt_r=3; reset pulsed with skid full -> out_valid=0, counters 0.

Source files
------------

// File: rtl/mini_riscv_decoder.sv
// mini_riscv_decoder
// Decodes the mini RISC-V subset (ADD/SUB/OR/AND/ADDI/BEQ, everything else
// ILLEGAL) between fetch and execute. The decoded result is held in a
// valid/ready output register that has a one-entry skid buffer behind it.
// Per-class saturating counters count results as the consumer takes them.
module mini_riscv_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,      // asynchronous, active-low
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [2:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [31:0]      out_imm,
  output logic             out_wr_en,
  output logic [CNT_W-1:0] cnt_r,
  output logic [CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_ill
);

  // Operation codes as presented on out_op (value 6 is never produced).
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_OR   = 3'd2,
    OP_AND  = 3'd3,
    OP_ADDI = 3'd4,
    OP_BEQ  = 3'd5,
    OP_ILL  = 3'd7
  } op_e;

  // One fully decoded instruction, as stored in the output and skid slots.
  typedef struct packed {
    logic [31:0] pc;
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        wr_en;
  } dec_t;

  // Occupancy of the output register / skid pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,   // nothing held, out_valid low
    ST_ONE   = 2'd1,   // output register holds a word
    ST_FULL  = 2'd2    // output register and skid both hold words
  } state_e;

  localparam logic [6:0] OPC_R    = 7'h33;
  localparam logic [6:0] OPC_ADDI = 7'h13;
  localparam logic [6:0] OPC_BEQ  = 7'h63;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Instruction fields
  logic [6:0] f_opcode;
  logic [4:0] f_rd;
  logic [2:0] f_funct3;
  logic [4:0] f_rs1;
  logic [4:0] f_rs2;
  logic [6:0] f_funct7;

  assign f_opcode = in_instr[6:0];
  assign f_rd     = in_instr[11:7];
  assign f_funct3 = in_instr[14:12];
  assign f_rs1    = in_instr[19:15];
  assign f_rs2    = in_instr[24:20];
  assign f_funct7 = in_instr[31:25];

  logic [31:0] imm_i;
  logic [31:0] imm_b;

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};

  // State
  state_e           state_q, state_d;
  dec_t             out_q, out_d;
  dec_t             skid_q, skid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_r_q, cnt_r_d;
  logic [CNT_W-1:0] cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;
  logic [CNT_W-1:0] cnt_ill_q, cnt_ill_d;

  dec_t dec;
  logic accept;
  logic consume;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign consume   = out_valid && out_ready;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Combinational decode of the offered instruction word.
  always_comb begin
    // NOTE: every field gets a default before the case so that no path
    // through the decode leaves a variable unassigned (which would infer a latch).
    dec     = '0;
    dec.pc  = in_pc;
    dec.op  = OP_ILL;
    case (f_opcode)
      OPC_R: begin
        case ({f_funct7, f_funct3})
          {7'h00, 3'b000}: dec.op = OP_ADD;
          {7'h20, 3'b000}: dec.op = OP_SUB;
          {7'h00, 3'b110}: dec.op = OP_OR;
          {7'h00, 3'b111}: dec.op = OP_AND;
          default:         dec.op = OP_ILL;
        endcase
        if (dec.op != OP_ILL) begin
          dec.rd    = f_rd;
          dec.rs1   = f_rs1;
          dec.rs2   = f_rs2;
          dec.wr_en = (f_rd != 5'd0);
        end
      end
      OPC_ADDI: begin
        if (f_funct3 == 3'b000) begin
          dec.op    = OP_ADDI;
          dec.rd    = f_rd;
          dec.rs1   = f_rs1;
          dec.imm   = imm_i;
          dec.wr_en = (f_rd != 5'd0);
        end
      end
      OPC_BEQ: begin
        if (f_funct3 == 3'b000) begin
          dec.op  = OP_BEQ;
          dec.rs1 = f_rs1;
          dec.rs2 = f_rs2;
          dec.imm = imm_b;
        end
      end
      default: ;
    endcase
  end

  // Next-state logic for the output register / skid occupancy FSM.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_d   = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          out_d = dec;
        end else if (accept) begin
          skid_d  = dec;
          state_d = ST_FULL;
        end else if (consume) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only the drain of the skid can happen.
        if (consume) begin
          out_d   = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // in_ready is registered: it reflects whether the skid will be free next cycle.
    in_ready_d = (state_d != ST_FULL);
  end

  // Retire counters: bump the class of the word leaving the output register.
  always_comb begin
    cnt_r_d   = cnt_r_q;
    cnt_i_d   = cnt_i_q;
    cnt_b_d   = cnt_b_q;
    cnt_ill_d = cnt_ill_q;
    if (consume) begin
      case (out_q.op)
        OP_ADD, OP_SUB, OP_OR, OP_AND: cnt_r_d   = sat_inc(cnt_r_q);
        OP_ADDI:                       cnt_i_d   = sat_inc(cnt_i_q);
        OP_BEQ:                        cnt_b_d   = sat_inc(cnt_b_q);
        default:                       cnt_ill_d = sat_inc(cnt_ill_q);
      endcase
    end
  end

  // State, data and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the data slots are reset too (not just the valid state) so
      // out_* reads as zero after reset and no old word survives a reset.
      state_q    <= ST_EMPTY;
      out_q      <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      cnt_r_q    <= '0;
      cnt_i_q    <= '0;
      cnt_b_q    <= '0;
      cnt_ill_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q    <= state_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_r_q    <= cnt_r_d;
      cnt_i_q    <= cnt_i_d;
      cnt_b_q    <= cnt_b_d;
      cnt_ill_q  <= cnt_ill_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_pc    = out_q.pc;
  assign out_op    = out_q.op;
  assign out_rd    = out_q.rd;
  assign out_rs1   = out_q.rs1;
  assign out_rs2   = out_q.rs2;
  assign out_imm   = out_q.imm;
  assign out_wr_en = out_q.wr_en;
  assign cnt_r     = cnt_r_q;
  assign cnt_i     = cnt_i_q;
  assign cnt_b     = cnt_b_q;
  assign cnt_ill   = cnt_ill_q;

endmodule

// File: tb/tb_mini_riscv_decoder.sv
// Directed bench for mini_riscv_decoder: single-word decodes, a stalled
// stream through the skid buffer, reset while full, and counter saturation
// (a second instance built with 2-bit counters shares the same stimulus).
module tb_mini_riscv_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, out_wr_en;
  logic [31:0] out_pc, out_imm;
  logic [2:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [15:0] cnt_r, cnt_i, cnt_b, cnt_ill;

  logic        s_in_ready, s_out_valid, s_out_wr_en;
  logic [31:0] s_out_pc, s_out_imm;
  logic [2:0]  s_out_op;
  logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
  logic [1:0]  s_cnt_r, s_cnt_i, s_cnt_b, s_cnt_ill;

  int n_vec = 0;
  int n_err = 0;

  mini_riscv_decoder #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_wr_en(out_wr_en),
    .cnt_r(cnt_r), .cnt_i(cnt_i), .cnt_b(cnt_b), .cnt_ill(cnt_ill)
  );

  mini_riscv_decoder #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(s_out_pc), .out_op(s_out_op),
    .out_rd(s_out_rd), .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_imm(s_out_imm),
    .out_wr_en(s_out_wr_en),
    .cnt_r(s_cnt_r), .cnt_i(s_cnt_i), .cnt_b(s_cnt_b), .cnt_ill(s_cnt_ill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer one word for a single cycle; it is accepted at that edge.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_dec(input string tag, input logic [31:0] pc, input logic [2:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic wr);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".pc"},    out_pc, pc);
    chk({tag, ".op"},    {29'd0, out_op}, {29'd0, op});
    chk({tag, ".rd"},    {27'd0, out_rd}, {27'd0, rd});
    chk({tag, ".rs1"},   {27'd0, out_rs1}, {27'd0, rs1});
    chk({tag, ".rs2"},   {27'd0, out_rs2}, {27'd0, rs2});
    chk({tag, ".imm"},   out_imm, imm);
    chk({tag, ".wr_en"}, {31'd0, out_wr_en}, {31'd0, wr});
  endtask

  initial begin
    int          tx;
    int          rx;
    logic        acc;
    logic        skid_fill;
    logic        stalled_prev;
    logic [31:0] held_pc;

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'd0;
    in_pc     = 32'd0;
    out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst.in_ready",  {31'd0, in_ready}, 32'd0);
    chk("rst.out_pc",    out_pc, 32'd0);
    chk("rst.out_imm",   out_imm, 32'd0);
    chk("rst.cnt_r",     {16'd0, cnt_r}, 32'd0);
    chk("rst.cnt_ill",   {16'd0, cnt_ill}, 32'd0);

    reset = 1'b1;
    tick();
    chk("rel.in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rel.out_valid", {31'd0, out_valid}, 32'd0);

    // Single words, one per cycle, each consumed on the following edge
    send(32'h00500093, 32'h0000_0100);   // ADDI x1,x0,5
    chk_dec("addi5", 32'h100, 3'd4, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    send(32'hFFF00113, 32'h0000_0104);   // ADDI x2,x0,-1
    chk_dec("addim1", 32'h104, 3'd4, 5'd2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1);
    send(32'h00000013, 32'h0000_0108);   // ADDI x0,x0,0
    chk_dec("addix0", 32'h108, 3'd4, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    send(32'h00000463, 32'h0000_010C);   // BEQ x0,x0,+8
    chk_dec("beq8", 32'h10C, 3'd5, 5'd0, 5'd0, 5'd0, 32'd8, 1'b0);
    send(32'hFE208EE3, 32'h0000_0110);   // BEQ x1,x2,-4
    chk_dec("beqm4", 32'h110, 3'd5, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
    send(32'h40110233, 32'h0000_0114);   // SUB x4,x2,x1
    chk_dec("sub", 32'h114, 3'd1, 5'd4, 5'd2, 5'd1, 32'd0, 1'b1);
    send(32'h007362B3, 32'h0000_0118);   // OR x5,x6,x7
    chk_dec("or", 32'h118, 3'd2, 5'd5, 5'd6, 5'd7, 32'd0, 1'b1);
    send(32'h003170B3, 32'h0000_011C);   // AND x1,x2,x3
    chk_dec("and", 32'h11C, 3'd3, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
    send(32'h002081B3, 32'h0000_0120);   // ADD x3,x1,x2
    chk_dec("add", 32'h120, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    send(32'h02110233, 32'h0000_0124);   // R-type with funct7=0x01
    chk_dec("ill_f7", 32'h124, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    send(32'h00000073, 32'h0000_0128);   // unsupported opcode
    chk_dec("ill_opc", 32'h128, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    send(32'h00101093, 32'h0000_012C);   // op 0x13 with funct3=001
    chk_dec("ill_f3", 32'h12C, 3'd7, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    tick();

    // Retired so far: 4 R, 3 ADDI, 2 BEQ, 3 ILLEGAL
    chk("idle.out_valid", {31'd0, out_valid}, 32'd0);
    chk("cnt_r",     {16'd0, cnt_r}, 32'd4);
    chk("cnt_i",     {16'd0, cnt_i}, 32'd3);
    chk("cnt_b",     {16'd0, cnt_b}, 32'd2);
    chk("cnt_ill",   {16'd0, cnt_ill}, 32'd3);
    chk("s.cnt_r",   {30'd0, s_cnt_r}, 32'd3);
    chk("s.cnt_i",   {30'd0, s_cnt_i}, 32'd3);
    chk("s.cnt_b",   {30'd0, s_cnt_b}, 32'd2);
    chk("s.cnt_ill", {30'd0, s_cnt_ill}, 32'd3);

    // Stream of 6 ADDIs, consumer stalled for cycles 2..4
    tx = 0;
    rx = 0;
    skid_fill    = 1'b0;
    stalled_prev = 1'b0;
    held_pc      = 32'd0;
    for (int c = 0; c < 40 && rx < 6; c++) begin
      in_valid  = (tx < 6);
      in_instr  = 32'h00100093;
      in_pc     = 32'h200 + 32'(tx) * 32'd4;
      out_ready = !(c >= 2 && c <= 4);
      if (skid_fill) chk("skid.in_ready", {31'd0, in_ready}, 32'd0);
      if (stalled_prev) chk("stall.pc_hold", out_pc, held_pc);
      acc          = in_valid && in_ready;
      skid_fill    = acc && out_valid && !out_ready;
      stalled_prev = out_valid && !out_ready;
      held_pc      = out_pc;
      if (out_valid && out_ready) begin
        chk("stream.pc", out_pc, 32'h200 + 32'(rx) * 32'd4);
        rx++;
      end
      if (acc) tx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream.count", 32'(rx), 32'd6);
    chk("stream.cnt_i", {16'd0, cnt_i}, 32'd9);

    // Fill output and skid, then reset in the middle of the cycle
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0000_0300);
    send(32'h002081B3, 32'h0000_0304);
    chk("full.in_ready",  {31'd0, in_ready}, 32'd0);
    chk("full.out_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst.in_ready",  {31'd0, in_ready}, 32'd0);
    chk("arst.out_pc",    out_pc, 32'd0);
    chk("arst.cnt_i",     {16'd0, cnt_i}, 32'd0);
    chk("arst.s.cnt_r",   {30'd0, s_cnt_r}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("rel2.in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("rel2.no_stale", {31'd0, out_valid}, 32'd0);

    // Five back-to-back ADDs: 16-bit counter reaches 5, 2-bit saturates at 3
    for (int k = 0; k < 5; k++) begin
      send(32'h002081B3, 32'h400 + 32'(k) * 32'd4);
    end
    tick();
    chk("sat.cnt_r",   {16'd0, cnt_r}, 32'd5);
    chk("sat.s.cnt_r", {30'd0, s_cnt_r}, 32'd3);
    chk("sat.s.cnt_i", {30'd0, s_cnt_i}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
